fifo_reader: RTL and testbench
==============================

Name: fifo_reader

Overview:
- Consumer-side controller for the project FIFO, complementing the write-side stimulus that drives sWrite/inputData.
- Decides when to pulse sRead from the FIFO status flags and captures the FIFO's registered read data.
- Absorbs the 1-cycle read latency in a small skid buffer and presents the words downstream on a valid/ready interface.
- Supports a threshold-gated streaming mode and an explicit flush mode that drains to empty.

Parameters:
- DATA_WIDTH, 8, width of FIFO words.
- SKID_DEPTH, 2, skid buffer entries; legal values are 2 or 4.
- CNT_WIDTH, 16, width of the optional statistics counter.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  asynchronous, active-low reset (0 = reset).
- ENB  in  1  block enable.
- flush  in  1  single-cycle pulse: drain the FIFO to empty regardless of threshold.
- fifoEmpty  in  1  FIFO empty flag.
- fifoAlmostEmpty  in  1  FIFO occupancy <= umbEmpty.
- fifoError  in  1  FIFO overflow/underflow error flag.
- outputData  in  DATA_WIDTH  FIFO read data; valid the cycle after sRead.
- sRead  out  1  FIFO read strobe.
- dataOut  out  DATA_WIDTH  downstream data (skid buffer head).
- validOut  out  1  dataOut valid.
- readyIn  in  1  downstream accepts when validOut && readyIn.
- busy  out  1  state != IDLE, or skid buffer non-empty.
- errOut  out  1  sticky error indication.

Behaviour:
- Reset (RST=0, asynchronous):
  - state=IDLE; sRead=0; validOut=0; dataOut=0; errOut=0; busy=0.
  - Skid occupancy=0; inflight=0.
- Read latency:
  - sRead high in cycle t means outputData is sampled at the end of cycle t+1 and pushed into the skid buffer.
  - inflight register = sRead delayed by one cycle.
- Issue rule (sRead, combinational from registered state):
  - Requires ENB, state in {STREAM, FLUSH}, and !fifoEmpty.
  - Also requires occ + inflight - pop < SKID_DEPTH, where pop = validOut && readyIn.
  - Consequence: continuous ready gives one word per cycle after a 2-cycle initial latency.
- Skid buffer:
  - Circular, SKID_DEPTH entries; push on inflight, pop on handshake; both allowed in the same cycle.
  - validOut = (occ != 0); dataOut = head entry. Data is held stable while validOut && !readyIn.
  - Occupancy never exceeds SKID_DEPTH (guaranteed by the issue rule); overflow is impossible by construction.
- States:
  - IDLE -> STREAM when ENB && !fifoAlmostEmpty.
  - IDLE -> FLUSH when ENB && flush.
  - STREAM -> IDLE when fifoAlmostEmpty (hysteresis: refill above threshold before resuming).
  - STREAM -> FLUSH on flush.
  - FLUSH -> IDLE when fifoEmpty && inflight==0.
  - Any state -> ERR when fifoError=1 is sampled. ERR sets errOut=1 and issues no reads.
  - ERR is left only by reset.
- ENB=0:
  - No new sRead; state is held.
  - In-flight data is still captured; downstream handshakes continue.
- Simultaneous events:
  - flush has priority over the threshold exit.
  - fifoError has priority over everything.
  - A flush pulse while already in FLUSH is ignored.
- Reset mid-operation: the skid buffer contents are discarded and any in-flight word is dropped.

Optional Feature:
- Macro: FIFO_READER_STATS_EN.
- Defined:
  - Adds output rdCount [CNT_WIDTH-1:0], which counts completed downstream handshakes.
  - Saturates at all-ones and resets to 0.
- Undefined: the port and the counter logic are absent; all other behaviour is identical.

Decomposition:
- Package fifo_reader_pkg:
  - State encoding: IDLE=2'd0, STREAM=2'd1, FLUSH=2'd2, ERR=2'd3.
  - Function for the occupancy pointer width: clog2(SKID_DEPTH)+1.
- Sub-module: fifo_reader_skid, holding the circular buffer, occupancy count and head/tail pointers, with push/pop/occ interface.
- The FSM and issue logic stay in the top module.

Test Plan:
- Reset, then hold fifoEmpty=1 and ENB=1 -> sRead never asserts; validOut=0; state stays IDLE.
- Model a FIFO preloaded with 6 words 0x33..0x38, umbEmpty=3, readyIn=1 -> sRead high 3 cycles (occupancy 6->3), outputs 0x33,0x34,0x35 in order, then IDLE.
- Same FIFO model, pulse flush -> all 6 words delivered back-to-back after a 2-cycle latency; busy drops the cycle after the last handshake.
- Stream with readyIn toggling 1,0,0,1 -> at most SKID_DEPTH words buffered, no word lost or duplicated, dataOut stable while stalled.
- Assert fifoError mid-stream -> next cycle errOut=1, sRead=0 forever; in-flight word still delivered; only RST=0 clears.
- With FIFO_READER_STATS_EN defined, flush 8 words 0xCC.. -> rdCount=8; reset mid-flush -> rdCount=0, validOut=0.

Source files
------------

// File: rtl/fifo_reader_pkg.sv
// Shared types and helpers for the fifo_reader consumer-side controller.
package fifo_reader_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2,
        ERR    = 2'd3
    } state_e;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_reader_skid.sv
// Circular skid buffer absorbing the FIFO's one-cycle read latency.
module fifo_reader_skid
    import fifo_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned SKID_DEPTH = 2,
    localparam int unsigned OW        = occ_width(SKID_DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [OW-1:0]         occ_o
);

    localparam int unsigned PW = $clog2(SKID_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
    logic [PW-1:0]         head_q;
    logic [PW-1:0]         tail_q;
    logic [OW-1:0]         occ_q;

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
            for (int unsigned i = 0; i < SKID_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_i) begin
                mem_q[tail_q] <= data_i;
                tail_q        <= tail_q + 1'b1;
            end
            if (pop_i) begin
                head_q <= head_q + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   occ_q <= occ_q + 1'b1;
                2'b01:   occ_q <= occ_q - 1'b1;
                default: ;
            endcase
        end
    end

    assign data_o = mem_q[head_q];
    assign occ_o  = occ_q;

endmodule

// File: rtl/fifo_reader.sv
// FIFO consumer: issues sRead, captures read data into a skid buffer, streams it out.
// Optional macro FIFO_READER_STATS_EN adds the rdCount handshake counter.
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned SKID_DEPTH = 2,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ENB,
    input  logic                  flush,
    input  logic                  fifoEmpty,
    input  logic                  fifoAlmostEmpty,
    input  logic                  fifoError,
    input  logic [DATA_WIDTH-1:0] outputData,
    output logic                  sRead,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  validOut,
    input  logic                  readyIn,
    output logic                  busy,
    output logic                  errOut
`ifdef FIFO_READER_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]  rdCount
`endif
);

    localparam int unsigned    OW      = occ_width(SKID_DEPTH);
    localparam logic [OW:0]    DEPTH_L = (OW+1)'(SKID_DEPTH);

    state_e        state_q;
    logic          inflight_q;
    logic          err_q;
    logic [OW-1:0] occ;
    logic          pop;
    logic [OW:0]   fill;
    logic [OW:0]   limit;

    assign validOut = (occ != '0);
    assign pop      = validOut && readyIn;

    // occ + inflight - pop < DEPTH, rearranged to avoid unsigned underflow.
    assign fill  = {1'b0, occ} + {{OW{1'b0}}, inflight_q};
    assign limit = DEPTH_L + {{OW{1'b0}}, pop};

    // STREAM stops reading in the same cycle the threshold flag rises,
    // since the state itself only leaves STREAM at the following edge.
    always_comb begin
        sRead = 1'b0;
        if (ENB && !fifoEmpty && (fill < limit)) begin
            case (state_q)
                STREAM:  sRead = !fifoAlmostEmpty;
                FLUSH:   sRead = 1'b1;
                default: sRead = 1'b0;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= sRead;
            if (fifoError) begin
                state_q <= ERR;
                err_q   <= 1'b1;
            end else if (ENB) begin
                case (state_q)
                    IDLE: begin
                        if (flush)                 state_q <= FLUSH;
                        else if (!fifoAlmostEmpty) state_q <= STREAM;
                    end
                    STREAM: begin
                        if (flush)                state_q <= FLUSH;
                        else if (fifoAlmostEmpty) state_q <= IDLE;
                    end
                    FLUSH: begin
                        if (fifoEmpty && !inflight_q) state_q <= IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    fifo_reader_skid #(
        .DATA_WIDTH (DATA_WIDTH),
        .SKID_DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk_i  (CLK),
        .rst_ni (RST),
        .push_i (inflight_q),
        .pop_i  (pop),
        .data_i (outputData),
        .data_o (dataOut),
        .occ_o  (occ)
    );

    assign busy   = (state_q != IDLE) || validOut;
    assign errOut = err_q;

`ifdef FIFO_READER_STATS_EN
    logic [CNT_WIDTH-1:0] cnt_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q <= '0;
        end else if (pop && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign rdCount = cnt_q;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader: queue-based FIFO model plus in-order scoreboard.
module tb_fifo_reader;

    localparam int DW  = 8;
    localparam int SD  = 2;
    localparam int UMB = 3;

    logic          CLK = 1'b0;
    logic          RST, ENB, flush, fifoEmpty, fifoAlmostEmpty, fifoError, readyIn;
    logic          sRead, validOut, busy, errOut;
    logic [DW-1:0] outputData, dataOut;
`ifdef FIFO_READER_STATS_EN
    logic [15:0]   rdCount;
`endif

    always #5 CLK = ~CLK;

    fifo_reader #(
        .DATA_WIDTH (DW),
        .SKID_DEPTH (SD),
        .CNT_WIDTH  (16)
    ) dut (
        .CLK             (CLK),
        .RST             (RST),
        .ENB             (ENB),
        .flush           (flush),
        .fifoEmpty       (fifoEmpty),
        .fifoAlmostEmpty (fifoAlmostEmpty),
        .fifoError       (fifoError),
        .outputData      (outputData),
        .sRead           (sRead),
        .dataOut         (dataOut),
        .validOut        (validOut),
        .readyIn         (readyIn),
        .busy            (busy),
        .errOut          (errOut)
`ifdef FIFO_READER_STATS_EN
        ,
        .rdCount         (rdCount)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [DW-1:0] fq[$];     // words held by the modelled FIFO
    logic [DW-1:0] exp_q[$];  // words read from the FIFO, not yet delivered downstream
    logic [DW-1:0] got_q[$];  // words delivered downstream
    bit            busy_log[$];
    int            cyc, n_reads, n_hs, first_hs, last_hs;
    bit            stall_prev;
    logic [DW-1:0] prev_d;

    // One clock cycle; caller has driven ENB/flush/readyIn/fifoError at the negedge.
    task automatic cycle();
        logic          sr, v, hs;
        logic [DW-1:0] d, w;
        fifoEmpty       = (fq.size() == 0);
        fifoAlmostEmpty = (fq.size() <= UMB);
        #1;
        sr = sRead; v = validOut; d = dataOut; hs = v && readyIn;
        busy_log.push_back(busy);
        if (sr) check("rd_guard", {30'd0, ENB, fifoEmpty}, 32'd2);
        if (stall_prev) begin
            check("hold_valid", v, 1);
            check("hold_data", d, prev_d);
        end
        stall_prev = v && !readyIn;
        prev_d     = d;
        @(posedge CLK);
        #1;
        if (hs) begin
            if (exp_q.size() == 0) check("spurious", 1, 0);
            else                   check("data", d, exp_q.pop_front());
            got_q.push_back(d);
            n_hs++;
            if (first_hs < 0) first_hs = cyc;
            last_hs = cyc;
        end
        if (sr && fq.size() > 0) begin
            w          = fq.pop_front();
            outputData = w;
            exp_q.push_back(w);
            n_reads++;
        end
        if (sr || hs) check("skid_bound", exp_q.size() <= SD, 1);
        cyc++;
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RST = 1'b0; ENB = 1'b0; flush = 1'b0; fifoError = 1'b0; readyIn = 1'b0;
        #2;
        check("rst_sread", sRead, 0);
        check("rst_valid", validOut, 0);
        check("rst_data", dataOut, 0);
        check("rst_err", errOut, 0);
        check("rst_busy", busy, 0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        fq.delete(); exp_q.delete(); got_q.delete(); busy_log.delete();
        stall_prev = 0; n_reads = 0; n_hs = 0; cyc = 0; first_hs = -1; last_hs = -1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit pat[4];
        int total;
        bit done;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        outputData = '0;
        fifoEmpty = 1'b1;
        fifoAlmostEmpty = 1'b1;
        @(negedge CLK);

        // Empty FIFO: nothing is ever read.
        do_reset();
        ENB = 1'b1; readyIn = 1'b1;
        repeat (10) cycle();
        check("empty_reads", n_reads, 0);
        check("empty_valid", validOut, 0);
        check("empty_busy", busy, 0);

        // Threshold streaming: 6 words, stop once occupancy reaches 3.
        do_reset();
        for (int i = 0; i < 6; i++) fq.push_back(DW'(8'h33 + i));
        ENB = 1'b1; readyIn = 1'b1;
        repeat (12) cycle();
        check("stream_reads", n_reads, 3);
        check("stream_count", got_q.size(), 3);
        for (int i = 0; i < 3 && i < got_q.size(); i++) check("stream_word", got_q[i], 8'h33 + i);
        check("stream_left", fq.size(), 3);
        check("stream_busy", busy, 0);

        // Flush: all 6 words back-to-back, first one 3 cycles after the pulse.
        do_reset();
        for (int i = 0; i < 6; i++) fq.push_back(DW'(8'h33 + i));
        ENB = 1'b1; readyIn = 1'b1; flush = 1'b1;
        cycle();
        flush = 1'b0;
        repeat (12) cycle();
        check("flush_count", n_hs, 6);
        check("flush_first", first_hs, 3);
        check("flush_span", last_hs - first_hs, 5);
        check("flush_busy_last", busy_log[last_hs], 1);
        check("flush_busy_after", busy_log[last_hs + 1], 0);
        check("flush_empty", fq.size(), 0);

        // Randomised stream with stalls, enable gaps and late writes, then a drain.
        do_reset();
        total = 40;
        for (int i = 0; i < 40; i++) fq.push_back(DW'($urandom));
        for (int k = 0; k < 120; k++) begin
            readyIn = (k < 40) ? pat[k % 4] : 1'($urandom);
            ENB     = ($urandom % 10) != 0;
            flush   = ENB && (($urandom % 24) == 0);
            if (($urandom % 4) == 0) begin
                fq.push_back(DW'($urandom));
                total++;
            end
            cycle();
        end
        ENB = 1'b1; flush = 1'b1;
        cycle();
        flush = 1'b0;
        done = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
            readyIn = 1'($urandom);
            cycle();
            done = (fq.size() == 0) && (exp_q.size() == 0) && !busy;
        end
        check("rand_drained", done, 1);
        check("rand_delivered", n_hs, total);
        check("rand_reads", n_reads, total);

        // Error mid-stream: in-flight word still delivered, no further reads.
        do_reset();
        for (int i = 0; i < 10; i++) fq.push_back(DW'(8'h50 + i));
        ENB = 1'b1; readyIn = 1'b1;
        repeat (3) cycle();
        fifoError = 1'b1;
        cycle();
        fifoError = 1'b0;
        check("err_set", errOut, 1);
        repeat (10) cycle();
        check("err_reads", n_reads, 3);
        check("err_delivered", n_hs, 3);
        check("err_last_word", got_q[got_q.size() - 1], 8'h52);
        check("err_sticky", errOut, 1);
        check("err_busy", busy, 1);
        do_reset();

`ifdef FIFO_READER_STATS_EN
        for (int i = 0; i < 8; i++) fq.push_back(DW'(8'hCC + i));
        ENB = 1'b1; readyIn = 1'b1; flush = 1'b1;
        cycle();
        flush = 1'b0;
        repeat (14) cycle();
        check("stats_count", rdCount, 8);
        for (int i = 0; i < 8; i++) fq.push_back(DW'(8'hCC + i));
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        repeat (5) cycle();
        check("stats_mid", rdCount > 8, 1);
        do_reset();
        check("stats_reset", rdCount, 0);
        check("stats_valid", validOut, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
